// File: rtl/telemetry_framer_if.sv
// rtl/telemetry_framer_if.sv - byte-transmitter handshake between the framer and a UART
// Signals:
//   uart_ready : transmitter can accept a byte (transmitter -> framer)
//   uart_trig  : one-cycle byte-load strobe (framer -> transmitter)
//   uart_data  : byte to transmit, valid while uart_trig=1 (framer -> transmitter)
//   uart_fini  : transmitter finished the current byte (transmitter -> framer)
// Modports: master = framer side, slave = transmitter side.
interface telemetry_framer_if;
    logic       uart_ready;
    logic       uart_trig;
    logic [7:0] uart_data;
    logic       uart_fini;

    modport master (
        input  uart_ready,
        input  uart_fini,
        output uart_trig,
        output uart_data
    );

    modport slave (
        output uart_ready,
        output uart_fini,
        input  uart_trig,
        input  uart_data
    );
endinterface

// File: rtl/telemetry_framer.sv
// rtl/telemetry_framer.sv - frames a latched payload as HEADER, [SEQ], payload bytes, checksum over a byte UART
// Optional feature: define TELEMETRY_FRAMER_SEQ_EN to insert an 8-bit sequence byte after HEADER.
// Parameters: NBYTES (payload bytes, 1..64), HEADER (start byte), CKSUM_MODE (0 = XOR, 1 = 8-bit sum).
// Ports:
//   Clock   : rising-edge clock
//   Reset   : asynchronous active-high reset
//   start   : frame request, sampled only while ready=1
//   payload : 8*NBYTES bits, byte 0 in the MSBs, sent first
//   ready   : idle and able to accept start
//   done    : one-cycle pulse after the last byte completes
//   uart    : transmitter handshake (uart_ready/uart_trig/uart_data/uart_fini)
module telemetry_framer #(
    parameter int         NBYTES     = 10,
    parameter logic [7:0] HEADER     = 8'h5A,
    parameter int         CKSUM_MODE = 0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic [8*NBYTES-1:0] payload,
    output logic                ready,
    output logic                done,
    telemetry_framer_if.master  uart
);

`ifdef TELEMETRY_FRAMER_SEQ_EN
    localparam int SEQ_LEN = 1;
`else
    localparam int SEQ_LEN = 0;
`endif
    localparam int FIRST_PAY = 1 + SEQ_LEN;
    localparam int FRAME_LEN = NBYTES + 2 + SEQ_LEN;
    localparam int IDX_W     = $clog2(NBYTES + 3);

    localparam logic [IDX_W-1:0] PAY_BEGIN = IDX_W'(FIRST_PAY);
    localparam logic [IDX_W-1:0] PAY_END   = IDX_W'(FIRST_PAY + NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, TRIG, WAIT_FINI, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [7:0]          acc;
    logic [8*NBYTES-1:0] pay_q;
    logic [7:0]          cur_byte;
    logic [7:0]          folded;
`ifdef TELEMETRY_FRAMER_SEQ_EN
    logic [7:0]          seq_q;
`endif

    // The payload buffer shifts left after each payload byte, so the byte
    // being sent is always the top byte of the buffer.
    always_comb begin
        cur_byte = acc;
        if (idx == '0) begin
            cur_byte = HEADER;
        end
`ifdef TELEMETRY_FRAMER_SEQ_EN
        else if (idx == IDX_W'(1)) begin
            cur_byte = seq_q;
        end
`endif
        else if (idx < PAY_END) begin
            cur_byte = pay_q[8*NBYTES-1 -: 8];
        end
    end

    assign folded = (CKSUM_MODE == 1) ? (acc + cur_byte) : (acc ^ cur_byte);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode from the state register only, so Reset forces them
    // without waiting for a clock edge.
    always_comb begin
        state_nxt      = state;
        ready          = 1'b0;
        done           = 1'b0;
        uart.uart_trig = 1'b0;
        uart.uart_data = 8'h00;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (uart.uart_ready) begin
                    state_nxt = TRIG;
                end
            end
            TRIG: begin
                uart.uart_trig = 1'b1;
                uart.uart_data = cur_byte;
                state_nxt      = WAIT_FINI;
            end
            WAIT_FINI: begin
                // uart_ready is not looked at here, so a ready/fini overlap
                // still costs a pass through WAIT_RDY before the next trig.
                if (uart.uart_fini) begin
                    state_nxt = (idx == LAST_IDX) ? DONE : WAIT_RDY;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            idx   <= '0;
            acc   <= 8'h00;
            pay_q <= '0;
`ifdef TELEMETRY_FRAMER_SEQ_EN
            seq_q <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pay_q <= payload;
                        acc   <= 8'h00;
                        idx   <= '0;
                    end
                end
                TRIG: begin
                    acc <= folded;
                end
                WAIT_FINI: begin
                    if (uart.uart_fini) begin
                        if (idx != LAST_IDX) begin
                            idx <= idx + IDX_W'(1);
                        end
                        if (idx >= PAY_BEGIN && idx < PAY_END) begin
                            pay_q <= pay_q << 8;
                        end
                    end
                end
                DONE: begin
`ifdef TELEMETRY_FRAMER_SEQ_EN
                    seq_q <= seq_q + 8'h01;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_framer.sv
// tb/tb_telemetry_framer.sv - directed self-checking bench for telemetry_framer
module tb_telemetry_framer;

`ifdef TELEMETRY_FRAMER_SEQ_EN
    localparam int SEQ_ON = 1;
`else
    localparam int SEQ_ON = 0;
`endif
    localparam int L10 = 12 + SEQ_ON;
    localparam int L1  = 3 + SEQ_ON;
    localparam int L64 = 66 + SEQ_ON;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    logic urdy;
    logic spur;
    int   fini_dly;
    logic start_v [4];
    logic [79:0]  p0;
    logic [79:0]  p1;
    logic [7:0]   p2;
    logic [511:0] p3;
    logic ready_w [4];
    logic done_w  [4];
    logic trig_w  [4];
    logic [7:0] data_w [4];
    bit   fini_m  [4];

    telemetry_framer_if if0 ();
    telemetry_framer_if if1 ();
    telemetry_framer_if if2 ();
    telemetry_framer_if if3 ();

    assign if0.uart_ready = urdy;
    assign if1.uart_ready = urdy;
    assign if2.uart_ready = urdy;
    assign if3.uart_ready = urdy;
    assign if0.uart_fini  = fini_m[0] | spur;
    assign if1.uart_fini  = fini_m[1] | spur;
    assign if2.uart_fini  = fini_m[2] | spur;
    assign if3.uart_fini  = fini_m[3] | spur;
    assign trig_w[0] = if0.uart_trig;
    assign trig_w[1] = if1.uart_trig;
    assign trig_w[2] = if2.uart_trig;
    assign trig_w[3] = if3.uart_trig;
    assign data_w[0] = if0.uart_data;
    assign data_w[1] = if1.uart_data;
    assign data_w[2] = if2.uart_data;
    assign data_w[3] = if3.uart_data;

    telemetry_framer #(.NBYTES(10), .CKSUM_MODE(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .start(start_v[0]), .payload(p0),
        .ready(ready_w[0]), .done(done_w[0]), .uart(if0));
    telemetry_framer #(.NBYTES(10), .CKSUM_MODE(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .start(start_v[1]), .payload(p1),
        .ready(ready_w[1]), .done(done_w[1]), .uart(if1));
    telemetry_framer #(.NBYTES(1), .CKSUM_MODE(0)) dut2 (
        .Clock(Clock), .Reset(Reset), .start(start_v[2]), .payload(p2),
        .ready(ready_w[2]), .done(done_w[2]), .uart(if2));
    telemetry_framer #(.NBYTES(64), .CKSUM_MODE(0)) dut3 (
        .Clock(Clock), .Reset(Reset), .start(start_v[3]), .payload(p3),
        .ready(ready_w[3]), .done(done_w[3]), .uart(if3));

    // Transmitter model: records each triggered byte and answers with
    // uart_fini fini_dly cycles later.
    logic [7:0] rx_buf [4][1024];
    int rx_cnt   [4];
    int done_cnt [4];
    int fini_cnt [4];
    int pend     [4];
    int dbl_cnt  [4];
    bit prev_trig [4];

    always @(negedge Clock) begin
        for (int k = 0; k < 4; k++) begin
            fini_m[k]    <= 1'b0;
            prev_trig[k] <= trig_w[k];
            if (prev_trig[k] && trig_w[k]) dbl_cnt[k] <= dbl_cnt[k] + 1;
            if (done_w[k]) done_cnt[k] <= done_cnt[k] + 1;
            if (fini_m[k]) fini_cnt[k] <= fini_cnt[k] + 1;
            if (trig_w[k]) begin
                if (rx_cnt[k] < 1024) rx_buf[k][rx_cnt[k]] <= data_w[k];
                rx_cnt[k] <= rx_cnt[k] + 1;
                pend[k]   <= fini_dly;
            end else if (pend[k] > 0) begin
                pend[k] <= pend[k] - 1;
                if (pend[k] == 1) fini_m[k] <= 1'b1;
            end
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] pay   [64];
    logic [7:0] exp_b [70];
    int         exp_n;
    logic [7:0] exp_seq [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic build_exp(input int nb, input logic [7:0] seqv, input int mode);
        logic [7:0] ck;
        exp_b[0] = 8'h5A;
        exp_n = 1;
        if (SEQ_ON == 1) begin
            exp_b[exp_n] = seqv;
            exp_n++;
        end
        for (int i = 0; i < nb; i++) begin
            exp_b[exp_n] = pay[i];
            exp_n++;
        end
        ck = 8'h00;
        for (int i = 0; i < exp_n; i++) ck = (mode == 1) ? ck + exp_b[i] : ck ^ exp_b[i];
        exp_b[exp_n] = ck;
        exp_n++;
    endtask

    task automatic load_pay(input int k);
        for (int i = 0; i < 10; i++) begin
            if (k == 0) p0[79-8*i -: 8] = pay[i];
            if (k == 1) p1[79-8*i -: 8] = pay[i];
        end
        if (k == 2) p2 = pay[0];
        if (k == 3) for (int i = 0; i < 64; i++) p3[511-8*i -: 8] = pay[i];
    endtask

    task automatic pulse_start(input int k);
        start_v[k] = 1'b1;
        @(negedge Clock);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input string tag, output int cyc);
        cyc = 1;
        while (!done_w[k] && cyc < 4000) begin
            @(negedge Clock);
            cyc++;
        end
        check({tag, " done seen"}, done_w[k], 1);
    endtask

    task automatic check_frame(input int k, input int base, input string tag);
        check({tag, " byte count"}, rx_cnt[k] - base, exp_n);
        for (int i = 0; i < exp_n; i++)
            check($sformatf("%s byte %0d", tag, i), rx_buf[k][base+i], exp_b[i]);
    endtask

    task automatic do_frame(input int k, input int nb, input int mode, input string tag,
                            output int cyc, output int base);
        base = rx_cnt[k];
        load_pay(k);
        build_exp(nb, exp_seq[k], mode);
        pulse_start(k);
        wait_done(k, tag, cyc);
        @(negedge Clock);
        check({tag, " done low after pulse"}, done_w[k], 0);
        check({tag, " ready back"}, ready_w[k], 1);
        check_frame(k, base, tag);
        exp_seq[k] = exp_seq[k] + 8'h01;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, base, dc, rc, fb, t;
        logic [7:0] ck_tab  [3];
        logic [7:0] sec_tab [3];

        ck_tab[0] = 8'h51;
        ck_tab[1] = (SEQ_ON == 1) ? 8'h50 : 8'h51;
        ck_tab[2] = (SEQ_ON == 1) ? 8'h53 : 8'h51;
        sec_tab[0] = (SEQ_ON == 1) ? 8'h00 : 8'h01;
        sec_tab[1] = 8'h01;
        sec_tab[2] = (SEQ_ON == 1) ? 8'h02 : 8'h01;

        Reset = 1'b1;
        urdy = 1'b1;
        spur = 1'b0;
        fini_dly = 1;
        for (int k = 0; k < 4; k++) begin
            start_v[k] = 1'b0;
            exp_seq[k] = 8'h00;
        end
        p0 = '0; p1 = '0; p2 = '0; p3 = '0;
        repeat (3) @(negedge Clock);
        check("reset ready", ready_w[0], 1);
        check("reset done", done_w[0], 0);
        check("reset trig", trig_w[0], 0);
        check("reset data", data_w[0], 0);
        check("reset ready nbytes64", ready_w[3], 1);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // all-zero payload: 5A, [00], ten 00, checksum 5A
        for (int i = 0; i < 64; i++) pay[i] = 8'h00;
        dc = done_cnt[0];
        do_frame(0, 10, 0, "zero", cyc, base);
        check("zero latency", cyc, 3*L10 + 1);
        check("zero first byte", rx_buf[0][base], 8'h5A);
        check("zero checksum", rx_buf[0][base+L10-1], 8'h5A);
        repeat (2) @(negedge Clock);
        check("zero done count", done_cnt[0] - dc, 1);

        // payload 01..0A: XOR checksum and additive checksum
        for (int i = 0; i < 10; i++) pay[i] = 8'(i + 1);
        do_frame(0, 10, 0, "xor", cyc, base);
        check("xor checksum", rx_buf[0][base+L10-1], (SEQ_ON == 1) ? 8'h50 : 8'h51);
        do_frame(1, 10, 1, "sum", cyc, base);
        check("sum latency", cyc, 3*L10 + 1);
        check("sum checksum", rx_buf[1][base+L10-1], 8'h91);

        // uart_ready held low, second start and payload change mid-frame
        load_pay(0);
        build_exp(10, exp_seq[0], 0);
        base = rx_cnt[0];
        urdy = 1'b0;
        pulse_start(0);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) p0 = '1;
            if (i == 10) start_v[0] = 1'b1;
            if (i == 11) start_v[0] = 1'b0;
            @(negedge Clock);
        end
        check("stall no trig", rx_cnt[0] - base, 0);
        check("stall ready low", ready_w[0], 0);
        urdy = 1'b1;
        wait_done(0, "stall", cyc);
        @(negedge Clock);
        check_frame(0, base, "stall");
        exp_seq[0] = exp_seq[0] + 8'h01;
        repeat (10) @(negedge Clock);
        check("stall trig total", rx_cnt[0] - base, L10);
        check("stall ready idle", ready_w[0], 1);
        load_pay(0);

        // reset mid-frame after the 4th uart_fini, checked before any clock edge
        base = rx_cnt[0];
        fb = fini_cnt[0];
        pulse_start(0);
        t = 0;
        while (fini_cnt[0] < fb + 4 && t < 200) begin @(negedge Clock); t++; end
        while (!trig_w[0] && t < 200) begin @(negedge Clock); t++; end
        check("abort reached 5th trig", trig_w[0], 1);
        Reset = 1'b1;
        #1;
        check("abort trig low", trig_w[0], 0);
        check("abort ready high", ready_w[0], 1);
        check("abort data zero", data_w[0], 0);
        check("abort done low", done_w[0], 0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) exp_seq[k] = 8'h00;
        rc = rx_cnt[0];
        repeat (6) @(negedge Clock);
        check("abort no more trig", rx_cnt[0] - rc, 0);
        check("abort still idle", ready_w[0], 1);

        // three frames after reset: SEQ byte and checksum per frame
        for (int f = 0; f < 3; f++) begin
            do_frame(0, 10, 0, $sformatf("seqf%0d", f), cyc, base);
            check($sformatf("seqf%0d header", f), rx_buf[0][base], 8'h5A);
            check($sformatf("seqf%0d second", f), rx_buf[0][base+1], sec_tab[f]);
            check($sformatf("seqf%0d checksum", f), rx_buf[0][base+L10-1], ck_tab[f]);
        end

        // NBYTES=1 with spurious uart_fini while waiting for uart_ready
        pay[0] = 8'hC3;
        load_pay(2);
        build_exp(1, exp_seq[2], 0);
        base = rx_cnt[2];
        urdy = 1'b0;
        pulse_start(2);
        for (int i = 0; i < 8; i++) begin
            spur = (i % 2 == 0);
            @(negedge Clock);
        end
        spur = 1'b0;
        check("n1 stalled", rx_cnt[2] - base, 0);
        urdy = 1'b1;
        wait_done(2, "n1", cyc);
        @(negedge Clock);
        check_frame(2, base, "n1");
        check("n1 checksum", rx_buf[2][base+L1-1], 8'h99);
        exp_seq[2] = exp_seq[2] + 8'h01;

        // NBYTES=64 random payload, fini in the cycle after trig
        for (int i = 0; i < 64; i++) pay[i] = 8'($urandom_range(0, 255));
        do_frame(3, 64, 0, "n64", cyc, base);
        check("n64 latency", cyc, 3*L64 + 1);

        // slower transmitter on the default configuration
        fini_dly = 3;
        for (int i = 0; i < 10; i++) pay[i] = 8'($urandom_range(0, 255));
        do_frame(0, 10, 0, "slow", cyc, base);
        fini_dly = 1;

        for (int k = 0; k < 4; k++)
            check($sformatf("back-to-back trig dut%0d", k), dbl_cnt[k], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
